u_lsu: RTL and testbench
========================

U_LSU -- requirements
Module: u_lsu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port lsu_req, input, 1 bit: request strobe, sampled only in IDLE.
REQ-004 SHALL have port lsu_we, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port lsu_funct3, input, 3 bits: RV32I width/sign code.
REQ-006 SHALL have port lsu_addr, input, 32 bits: byte address.
REQ-007 SHALL have port lsu_wd, input, 32 bits: store data, right-aligned.
REQ-008 SHALL have port lsu_busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port lsu_done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port lsu_err, output, 1 bit: valid with lsu_done; access rejected.
REQ-011 SHALL have port lsu_rd, output, 32 bits: extended load result, valid with lsu_done.
REQ-012 SHALL have port dat_a, output, 16 bits: SRAM word address (byte address bits [17:2]).
REQ-013 SHALL have port dat_we, output, 4 bits: byte-lane write strobes.
REQ-014 SHALL have port dat_wd, output, 32 bits: lane-aligned write data.
REQ-015 SHALL have port dat_re, output, 4 bits: byte-lane read enables.
REQ-016 SHALL have port dat_rd, input, 32 bits: SRAM read data, valid one cycle after dat_re.

Function
REQ-017 SHALL implement states IDLE, A0, A1, FIN and DONE.
REQ-018 In IDLE with lsu_req=1, SHALL register the request and go to A0, or go straight to DONE with lsu_err=1 if the request is illegal.
REQ-019 A request SHALL be illegal for load funct3 011/110/111, for store funct3 other than 000/001/010, or when the byte span [addr, addr+size-1] exceeds 0x3FFFF.
REQ-020 A0 SHALL drive the first word access; an access crossing a word boundary (LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[1:0]=3) SHALL then go to A1, which drives word address +1.
REQ-021 After the last access, loads SHALL go to FIN (capture dat_rd) and then DONE; stores SHALL go directly to DONE.
REQ-022 DONE SHALL last one cycle, assert lsu_done, and return to IDLE.
REQ-023 Latency from the request cycle T SHALL be: aligned load T+3, split load T+4, aligned store T+2, split store T+3, error T+1.
REQ-024 Lane enables SHALL cover exactly the bytes accessed in each word; split stores SHALL use the upper lanes in word 0 (data shifted left by 8*addr[1:0]) and the lower lanes in word 1 (data shifted right by 32-8*addr[1:0]).
REQ-025 Load bytes SHALL be reassembled little-endian; LB/LH SHALL sign-extend from bit 7/15, and LBU/LHU SHALL zero-extend.
REQ-026 dat_we and dat_re SHALL be 0 outside A0/A1; dat_we SHALL never be nonzero for a load.
REQ-027 lsu_req outside IDLE SHALL be ignored, with no queuing.
REQ-028 lsu_rd SHALL hold its value until the next lsu_done and SHALL be 0 on an errored or store completion.

Reset
REQ-029 rstn low SHALL immediately force IDLE and set all outputs to 0, including any operation in progress; an aborted store SHALL have written only the lanes strobed before reset.
REQ-030 The first request SHALL be accepted on the first rising edge with rstn high.

Structure
REQ-031 Package u_lsu_pkg SHALL hold the state enum, the funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW) and the SRAM byte limit 0x3FFFF.
REQ-032 Load extraction and extension SHALL live in one combinational sub-module, u_lsu_ext; the FSM, lane and strobe logic SHALL stay in u_lsu.

Verification
REQ-033 SW addr 0x100 wd 0xA1B2C3D4 -> A0: dat_a=0x0040, dat_we=1111, dat_wd=0xA1B2C3D4; lsu_done at T+2, err=0.
REQ-034 LB addr 0x103 with word 0x80000000 -> dat_re=1000; lsu_rd=0xFFFFFF80 at T+3; LBU at the same address -> 0x00000080.
REQ-035 SW addr 0x101 wd 0x11223344 -> word 0x40: we=1110, wd=0x22334400; word 0x41: we=0001, wd=0x00000011; done at T+3.
REQ-036 LH addr 0x3FFFF -> no SRAM strobes, lsu_done=lsu_err=1 at T+1; load funct3=011 -> same response.
REQ-037 rstn pulled low during A1 of a split load -> outputs 0 immediately, no lsu_done; after release, a LW addr 0x0 completes normally at T+3.
REQ-038 lsu_req held high through a busy LW -> exactly one lsu_done, then the next request is accepted the cycle after DONE.

Source files
------------

// File: rtl/u_lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   state_e           : FSM state encoding
//   F3_*              : RV32I load/store width codes
//   SRAM_BYTE_LIMIT   : highest legal byte address of the data SRAM
//   lsu_access_legal  : request legality check (width code and address span)
package u_lsu_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned SRAM_AW = 18;  // byte address bits reaching the SRAM
   localparam int unsigned WORD_AW = 16;  // SRAM word address width
   localparam int unsigned NLANE   = 4;

   localparam logic [XLEN-1:0] SRAM_BYTE_LIMIT = 32'h0003_FFFF;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_A0   = 3'd1,
      ST_A1   = 3'd2,
      ST_FIN  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Legal when the width code exists for the direction and the last byte fits in the SRAM.
   function automatic logic lsu_access_legal(input logic            i_we,
                                             input logic [2:0]      i_f3,
                                             input logic [XLEN-1:0] i_addr);
      logic          f3_ok;
      logic [XLEN:0] last;
      if (i_we) f3_ok = (i_f3 == F3_SB) || (i_f3 == F3_SH) || (i_f3 == F3_SW);
      else      f3_ok = (i_f3 == F3_LB) || (i_f3 == F3_LH) || (i_f3 == F3_LW) ||
                        (i_f3 == F3_LBU) || (i_f3 == F3_LHU);
      case (i_f3[1:0])
         2'b00:   last = {1'b0, i_addr};
         2'b01:   last = {1'b0, i_addr} + 33'd1;
         default: last = {1'b0, i_addr} + 33'd3;
      endcase
      return f3_ok && (last <= 33'(SRAM_BYTE_LIMIT));
   endfunction

endpackage

// File: rtl/u_lsu_ext.sv
// Load data extraction: picks the accessed bytes out of one or two SRAM words
// (little-endian) and sign/zero-extends them.
//   i_w0     : first word read (lower addresses)
//   i_w1     : second word read (same as i_w0 for non-split accesses)
//   i_off    : byte offset addr[1:0]
//   i_funct3 : load width/sign code
//   o_rd_c   : extended result (combinational)
module u_lsu_ext
   import u_lsu_pkg::*;
(
   input  logic [XLEN-1:0] i_w0,
   input  logic [XLEN-1:0] i_w1,
   input  logic [1:0]      i_off,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_rd_c
);

   logic [2*XLEN-1:0] w_cat;
   logic [XLEN-1:0]   w_sh;

   always_comb begin
      w_cat = {i_w1, i_w0};
      w_sh  = XLEN'(w_cat >> {i_off, 3'b000});
      case (i_funct3)
         F3_LB:   o_rd_c = {{24{w_sh[7]}}, w_sh[7:0]};
         F3_LH:   o_rd_c = {{16{w_sh[15]}}, w_sh[15:0]};
         F3_LW:   o_rd_c = w_sh;
         F3_LBU:  o_rd_c = {24'h0, w_sh[7:0]};
         F3_LHU:  o_rd_c = {16'h0, w_sh[15:0]};
         default: o_rd_c = '0;
      endcase
   end

endmodule

// File: rtl/u_lsu.sv
// RV32I load/store unit driving a single-port byte-laned SRAM.
// Handles misaligned accesses by splitting them over two consecutive words.
//   clk, rstn               : clock, async active-low reset
//   lsu_req/we/funct3/addr/wd : request from the core (sampled in IDLE)
//   lsu_busy/done/err/rd    : status and load result
//   dat_a/we/wd/re/rd       : SRAM port (dat_rd valid one cycle after dat_re)
module u_lsu
   import u_lsu_pkg::*;
(
   input  logic               clk,
   input  logic               rstn,
   input  logic               lsu_req,
   input  logic               lsu_we,
   input  logic [2:0]         lsu_funct3,
   input  logic [XLEN-1:0]    lsu_addr,
   input  logic [XLEN-1:0]    lsu_wd,
   output logic               lsu_busy,
   output logic               lsu_done,
   output logic               lsu_err,
   output logic [XLEN-1:0]    lsu_rd,
   output logic [WORD_AW-1:0] dat_a,
   output logic [NLANE-1:0]   dat_we,
   output logic [XLEN-1:0]    dat_wd,
   output logic [NLANE-1:0]   dat_re,
   input  logic [XLEN-1:0]    dat_rd
);

   state_e r_state;
   state_e w_nxt_state;

   logic               r_we;
   logic [2:0]         r_f3;
   logic [SRAM_AW-1:0] r_addr;
   logic [XLEN-1:0]    r_wd;
   logic [XLEN-1:0]    r_w0;

   logic               w_op_we;
   logic [2:0]         w_op_f3;
   logic [SRAM_AW-1:0] w_op_addr;
   logic [XLEN-1:0]    w_op_wd;
   logic [NLANE-1:0]   w_size_mask;
   logic [XLEN-1:0]    w_wd_m;
   logic [2*NLANE-1:0] w_lanes;
   logic [2*XLEN-1:0]  w_wd_sh;
   logic               w_split;
   logic               w_legal;

   logic [WORD_AW-1:0] w_a_nxt;
   logic [NLANE-1:0]   w_we_nxt;
   logic [NLANE-1:0]   w_re_nxt;
   logic [XLEN-1:0]    w_wd_nxt;
   logic [XLEN-1:0]    w_rd_nxt;
   logic               w_err_nxt;
   logic [XLEN-1:0]    w_ext_w0;
   logic [XLEN-1:0]    w_rd_ext;

   // Operand source: live inputs while accepting, captured request afterwards.
   always_comb begin
      w_op_we   = (r_state == ST_IDLE) ? lsu_we : r_we;
      w_op_f3   = (r_state == ST_IDLE) ? lsu_funct3 : r_f3;
      w_op_addr = (r_state == ST_IDLE) ? lsu_addr[SRAM_AW-1:0] : r_addr;
      w_op_wd   = (r_state == ST_IDLE) ? lsu_wd : r_wd;
      case (w_op_f3[1:0])
         2'b00: begin
            w_size_mask = 4'b0001;
            w_wd_m      = {24'h0, w_op_wd[7:0]};
         end
         2'b01: begin
            w_size_mask = 4'b0011;
            w_wd_m      = {16'h0, w_op_wd[15:0]};
         end
         default: begin
            w_size_mask = 4'b1111;
            w_wd_m      = w_op_wd;
         end
      endcase
      // Lanes/data over a two-word window: low half is word 0, high half word 1.
      w_lanes = {4'b0000, w_size_mask} << w_op_addr[1:0];
      w_wd_sh = {32'h0, w_wd_m} << {w_op_addr[1:0], 3'b000};
      w_split = |w_lanes[2*NLANE-1:NLANE];
      w_legal = lsu_access_legal(lsu_we, lsu_funct3, lsu_addr);
   end

   // Next state and next registered output values.
   always_comb begin
      w_nxt_state = r_state;
      w_err_nxt   = 1'b0;
      w_a_nxt     = '0;
      w_we_nxt    = '0;
      w_re_nxt    = '0;
      w_wd_nxt    = '0;
      w_rd_nxt    = lsu_rd;

      case (r_state)
         ST_IDLE: begin
            if (lsu_req) begin
               if (w_legal) begin
                  w_nxt_state = ST_A0;
               end else begin
                  w_nxt_state = ST_DONE;
                  w_err_nxt   = 1'b1;
               end
            end
         end
         ST_A0:   w_nxt_state = w_split ? ST_A1 : (r_we ? ST_DONE : ST_FIN);
         ST_A1:   w_nxt_state = r_we ? ST_DONE : ST_FIN;
         ST_FIN:  w_nxt_state = ST_DONE;
         ST_DONE: w_nxt_state = ST_IDLE;
         default: w_nxt_state = ST_IDLE;
      endcase

      if (w_nxt_state == ST_A0) begin
         w_a_nxt = w_op_addr[SRAM_AW-1:2];
         if (w_op_we) begin
            w_we_nxt = w_lanes[NLANE-1:0];
            w_wd_nxt = w_wd_sh[XLEN-1:0];
         end else begin
            w_re_nxt = w_lanes[NLANE-1:0];
         end
      end else if (w_nxt_state == ST_A1) begin
         w_a_nxt = w_op_addr[SRAM_AW-1:2] + 16'd1;
         if (w_op_we) begin
            w_we_nxt = w_lanes[2*NLANE-1:NLANE];
            w_wd_nxt = w_wd_sh[2*XLEN-1:XLEN];
         end else begin
            w_re_nxt = w_lanes[2*NLANE-1:NLANE];
         end
      end

      // Only loads pass through FIN; stores and rejected requests report zero.
      if (w_nxt_state == ST_DONE) begin
         w_rd_nxt = (r_state == ST_FIN) ? w_rd_ext : '0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_nxt_state;
   end

   // Request capture, first-word capture for split loads, and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_we     <= 1'b0;
         r_f3     <= '0;
         r_addr   <= '0;
         r_wd     <= '0;
         r_w0     <= '0;
         lsu_busy <= 1'b0;
         lsu_done <= 1'b0;
         lsu_err  <= 1'b0;
         lsu_rd   <= '0;
         dat_a    <= '0;
         dat_we   <= '0;
         dat_wd   <= '0;
         dat_re   <= '0;
      end else begin
         if ((r_state == ST_IDLE) && lsu_req && w_legal) begin
            r_we   <= lsu_we;
            r_f3   <= lsu_funct3;
            r_addr <= lsu_addr[SRAM_AW-1:0];
            r_wd   <= lsu_wd;
         end
         if ((r_state == ST_A1) && !r_we) r_w0 <= dat_rd;
         lsu_busy <= (w_nxt_state != ST_IDLE);
         lsu_done <= (w_nxt_state == ST_DONE);
         lsu_err  <= w_err_nxt;
         lsu_rd   <= w_rd_nxt;
         dat_a    <= w_a_nxt;
         dat_we   <= w_we_nxt;
         dat_wd   <= w_wd_nxt;
         dat_re   <= w_re_nxt;
      end
   end

   // In FIN dat_rd holds the last word; split loads pair it with the word kept from A1.
   assign w_ext_w0 = w_split ? r_w0 : dat_rd;

   u_lsu_ext u_ext (
      .i_w0     (w_ext_w0),
      .i_w1     (dat_rd),
      .i_off    (r_addr[1:0]),
      .i_funct3 (r_f3),
      .o_rd_c   (w_rd_ext)
   );

endmodule

// File: tb/tb_u_lsu.sv
// Directed bench for u_lsu with a behavioural byte-laned SRAM.
module tb_u_lsu;

   localparam logic [2:0] F_LB  = 3'b000;
   localparam logic [2:0] F_LH  = 3'b001;
   localparam logic [2:0] F_LW  = 3'b010;
   localparam logic [2:0] F_LBU = 3'b100;
   localparam logic [2:0] F_LHU = 3'b101;
   localparam logic [2:0] F_SB  = 3'b000;
   localparam logic [2:0] F_SH  = 3'b001;
   localparam logic [2:0] F_SW  = 3'b010;

   logic        clk        = 1'b0;
   logic        rstn       = 1'b0;
   logic        lsu_req    = 1'b0;
   logic        lsu_we     = 1'b0;
   logic [2:0]  lsu_funct3 = 3'b0;
   logic [31:0] lsu_addr   = 32'h0;
   logic [31:0] lsu_wd     = 32'h0;
   logic        lsu_busy;
   logic        lsu_done;
   logic        lsu_err;
   logic [31:0] lsu_rd;
   logic [15:0] dat_a;
   logic [3:0]  dat_we;
   logic [31:0] dat_wd;
   logic [3:0]  dat_re;
   logic [31:0] dat_rd;

   logic [31:0] mem [0:65535];

   int total = 0;
   int bad   = 0;

   int          lat;
   int          dcount;
   logic [15:0] a0, a1;
   logic [3:0]  we0, we1, re0, re1, we_or, re_or;
   logic [31:0] wd0, wd1, rd_q;
   logic        err_q;

   u_lsu dut (
      .clk        (clk),
      .rstn       (rstn),
      .lsu_req    (lsu_req),
      .lsu_we     (lsu_we),
      .lsu_funct3 (lsu_funct3),
      .lsu_addr   (lsu_addr),
      .lsu_wd     (lsu_wd),
      .lsu_busy   (lsu_busy),
      .lsu_done   (lsu_done),
      .lsu_err    (lsu_err),
      .lsu_rd     (lsu_rd),
      .dat_a      (dat_a),
      .dat_we     (dat_we),
      .dat_wd     (dat_wd),
      .dat_re     (dat_re),
      .dat_rd     (dat_rd)
   );

   always #5 clk = ~clk;

   // SRAM: per-lane writes, registered read one cycle after dat_re.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (dat_we[i]) mem[dat_a][8*i +: 8] <= dat_wd[8*i +: 8];
      dat_rd <= (dat_re != 4'b0) ? mem[dat_a] : 32'h0;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic sample;
      if (lat == 1) begin a0 = dat_a; we0 = dat_we; re0 = dat_re; wd0 = dat_wd; end
      if (lat == 2) begin a1 = dat_a; we1 = dat_we; re1 = dat_re; wd1 = dat_wd; end
      we_or = we_or | dat_we;
      re_or = re_or | dat_re;
   endtask

   // One-cycle request, then wait (bounded) for lsu_done and step back to IDLE.
   task automatic run_op(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
      lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wd = wd;
      a0 = '0; a1 = '0; we0 = '0; we1 = '0; re0 = '0; re1 = '0; wd0 = '0; wd1 = '0;
      we_or = '0; re_or = '0;
      tick;
      lsu_req = 1'b0;
      lat = 1;
      sample();
      while (lsu_done !== 1'b1 && lat < 12) begin
         tick;
         lat++;
         sample();
      end
      rd_q  = lsu_rd;
      err_q = lsu_err;
      tick;
   endtask

   initial begin
      // Reset values
      tick; tick;
      chk("rst_busy", 32'(lsu_busy), 32'h0);
      chk("rst_done", 32'(lsu_done), 32'h0);
      chk("rst_rd",   lsu_rd, 32'h0);
      chk("rst_sram", {dat_a, 4'h0, dat_we, 4'h0, dat_re}, 32'h0);

      // First request on the first edge after reset release: aligned SW
      rstn = 1'b1;
      run_op(1'b1, F_SW, 32'h100, 32'hA1B2C3D4);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_a0",  32'(a0), 32'h40);
      chk("sw_we0", 32'(we0), 32'hF);
      chk("sw_wd0", wd0, 32'hA1B2C3D4);
      chk("sw_err", 32'(err_q), 32'h0);
      chk("sw_rd",  rd_q, 32'h0);
      chk("sw_mem", mem[16'h40], 32'hA1B2C3D4);
      chk("sw_idle_busy", 32'(lsu_busy), 32'h0);

      // Byte loads with sign/zero extension
      run_op(1'b1, F_SW, 32'h100, 32'h80000000);
      run_op(1'b0, F_LB, 32'h103, 32'h0);
      chk("lb_lat", 32'(lat), 32'd3);
      chk("lb_re0", 32'(re0), 32'h8);
      chk("lb_noweload", 32'(we_or), 32'h0);
      chk("lb_rd",  rd_q, 32'hFFFFFF80);
      run_op(1'b0, F_LBU, 32'h103, 32'h0);
      chk("lbu_lat", 32'(lat), 32'd3);
      chk("lbu_rd",  rd_q, 32'h00000080);

      // Split store
      run_op(1'b1, F_SW, 32'h101, 32'h11223344);
      chk("sws_lat", 32'(lat), 32'd3);
      chk("sws_a0",  32'(a0), 32'h40);
      chk("sws_we0", 32'(we0), 32'hE);
      chk("sws_wd0", wd0, 32'h22334400);
      chk("sws_a1",  32'(a1), 32'h41);
      chk("sws_we1", 32'(we1), 32'h1);
      chk("sws_wd1", wd1, 32'h00000011);
      chk("sws_rd",  rd_q, 32'h0);
      chk("sws_mem0", mem[16'h40], 32'h22334400);
      chk("sws_mem1", 32'(mem[16'h41][7:0]), 32'h11);

      // Split load reassembly
      run_op(1'b0, F_LW, 32'h101, 32'h0);
      chk("lws_lat", 32'(lat), 32'd4);
      chk("lws_re0", 32'(re0), 32'hE);
      chk("lws_re1", 32'(re1), 32'h1);
      chk("lws_rd",  rd_q, 32'h11223344);

      // Halfword store/load in the upper lanes
      run_op(1'b1, F_SH, 32'h106, 32'hFFFF8001);
      chk("sh_lat", 32'(lat), 32'd2);
      chk("sh_we0", 32'(we0), 32'hC);
      chk("sh_wd0", wd0, 32'h80010000);
      run_op(1'b0, F_LH, 32'h106, 32'h0);
      chk("lh_lat", 32'(lat), 32'd3);
      chk("lh_rd",  rd_q, 32'hFFFF8001);
      tick;
      chk("lh_rd_hold", lsu_rd, 32'hFFFF8001);
      run_op(1'b0, F_LHU, 32'h106, 32'h0);
      chk("lhu_rd", rd_q, 32'h00008001);

      // Rejected requests
      run_op(1'b0, F_LH, 32'h3FFFF, 32'h0);
      chk("elh_lat",  32'(lat), 32'd1);
      chk("elh_err",  32'(err_q), 32'h1);
      chk("elh_rd",   rd_q, 32'h0);
      chk("elh_strb", {24'h0, we_or, re_or}, 32'h0);
      run_op(1'b0, 3'b011, 32'h100, 32'h0);
      chk("ef3_lat", 32'(lat), 32'd1);
      chk("ef3_err", 32'(err_q), 32'h1);
      chk("ef3_strb", {24'h0, we_or, re_or}, 32'h0);
      run_op(1'b1, 3'b100, 32'h100, 32'h0);
      chk("esf3_err", 32'(err_q), 32'h1);
      chk("esf3_we",  32'(we_or), 32'h0);
      run_op(1'b1, F_SW, 32'h3FFFD, 32'h0);
      chk("esw_err", 32'(err_q), 32'h1);
      chk("esw_lat", 32'(lat), 32'd1);

      // Last legal byte
      run_op(1'b1, F_SB, 32'h3FFFF, 32'h0000005A);
      chk("sbl_lat", 32'(lat), 32'd2);
      chk("sbl_err", 32'(err_q), 32'h0);
      chk("sbl_a0",  32'(a0), 32'hFFFF);
      chk("sbl_we0", 32'(we0), 32'h8);
      chk("sbl_wd0", wd0, 32'h5A000000);

      // Reset during A1 of a split load
      run_op(1'b1, F_SW, 32'h0, 32'hCAFEF00D);
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = F_LW; lsu_addr = 32'h101;
      tick;
      lsu_req = 1'b0;
      tick;
      chk("ra1_a",  32'(dat_a), 32'h41);
      chk("ra1_re", 32'(dat_re), 32'h1);
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(lsu_busy), 32'h0);
      chk("rst_mid_sram", {dat_a, 4'h0, dat_we, 4'h0, dat_re}, 32'h0);
      tick;
      chk("rst_mid_done0", 32'(lsu_done), 32'h0);
      tick;
      chk("rst_mid_done1", 32'(lsu_done), 32'h0);
      rstn = 1'b1;
      run_op(1'b0, F_LW, 32'h0, 32'h0);
      chk("rlw_lat", 32'(lat), 32'd3);
      chk("rlw_rd",  rd_q, 32'hCAFEF00D);

      // Request held high through a busy load
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = F_LW; lsu_addr = 32'h0;
      dcount = 0;
      repeat (3) begin
         tick;
         if (lsu_done === 1'b1) dcount++;
      end
      chk("hold_done3", 32'(lsu_done), 32'h1);
      chk("hold_cnt",   32'(dcount), 32'd1);
      chk("hold_rd",    lsu_rd, 32'hCAFEF00D);
      tick;
      chk("hold_idle",  {31'h0, lsu_busy} | {30'h0, lsu_done, 1'b0}, 32'h0);
      tick;
      chk("hold_accept", 32'(lsu_busy), 32'h1);
      lsu_req = 1'b0;
      lat = 1;
      while (lsu_done !== 1'b1 && lat < 12) begin
         tick;
         lat++;
      end
      chk("hold2_lat", 32'(lat), 32'd3);
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
